inst_fetch_bridge: RTL and testbench

- Sits between the CPU core's instruction-ROM port (rom_ce/rom_addr/rom_data) and a slow external instruction memory that uses a req/ack handshake.
- Holds a one-entry fetch buffer. On a hit it returns the instruction in the same cycle.
- On a miss it raises stall_o to pipeline control and runs a handshake FSM to fill the buffer.
- A timeout watchdog substitutes a NOP if memory never acknowledges.

---
 rtl/inst_fetch_bridge.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// One-entry instruction fetch buffer bridging the CPU ROM port to a slow req/ack memory.
// Optional second (prefetch) entry and PREFETCH state when INST_PREFETCH_EN is defined.
module inst_fetch_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              fetch_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_PREFETCH = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_buf_valid;
  logic [ADDR_W-1:0]   r_buf_addr;
  logic [DATA_W-1:0]   r_buf_data;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_buf_hit;
  logic                w_hit;
  logic                w_miss;
  logic                w_timeout;
  logic                w_done;
  logic [DATA_W-1:0]   w_fill_data;

  assign w_buf_hit = rom_ce_i && r_buf_valid && (rom_addr_i == r_buf_addr);

`ifdef INST_PREFETCH_EN
  logic                r_pf_valid;
  logic [ADDR_W-1:0]   r_pf_addr;
  logic [DATA_W-1:0]   r_pf_data;
  logic                w_pf_hit;
  logic [ADDR_W-1:0]   w_next_addr;

  assign w_pf_hit    = rom_ce_i && r_pf_valid && (rom_addr_i == r_pf_addr);
  assign w_next_addr = r_buf_addr + ADDR_W'(4);
  assign w_hit       = w_buf_hit || w_pf_hit;
  assign rom_data_o  = w_buf_hit ? r_buf_data : (w_pf_hit ? r_pf_data : '0);
`else
  assign w_hit       = w_buf_hit;
  assign rom_data_o  = w_buf_hit ? r_buf_data : '0;
`endif

  assign w_miss      = rom_ce_i && !w_hit;
  assign stall_o     = w_miss;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_done      = mem_ack_i || w_timeout;
  // A timed-out fetch is filled with an all-zero NOP.
  assign w_fill_data = mem_ack_i ? mem_rdata_i : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_cnt       <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      fetch_err_o <= 1'b0;
`ifdef INST_PREFETCH_EN
      r_pf_valid  <= 1'b0;
      r_pf_addr   <= '0;
      r_pf_data   <= '0;
`endif
    end else begin
      fetch_err_o <= 1'b0;
`ifdef INST_PREFETCH_EN
      // Promote a consumed prefetch entry into the main buffer.
      if (w_pf_hit && !w_buf_hit) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= r_pf_addr;
        r_buf_data  <= r_pf_data;
        r_pf_valid  <= 1'b0;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            mem_addr_o <= rom_addr_i;
            mem_req_o  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end
`ifdef INST_PREFETCH_EN
          else if (r_buf_valid && !w_pf_hit &&
                   !(r_pf_valid && (r_pf_addr == w_next_addr))) begin
            mem_addr_o <= w_next_addr;
            mem_req_o  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_PREFETCH;
          end
`endif
        end
        S_WAIT: begin
          if (w_done) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= mem_addr_o;
            r_buf_data  <= w_fill_data;
            mem_req_o   <= 1'b0;
            fetch_err_o <= !mem_ack_i;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef INST_PREFETCH_EN
        S_PREFETCH: begin
          if (w_done) begin
            r_pf_valid  <= 1'b1;
            r_pf_addr   <= mem_addr_o;
            r_pf_data   <= w_fill_data;
            mem_req_o   <= 1'b0;
            fetch_err_o <= !mem_ack_i;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge (default single-entry build) against a transaction-level model.
module tb_inst_fetch_bridge;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_i;
  logic [AW-1:0] rom_addr_i;
  logic [DW-1:0] rom_data_o;
  logic          stall_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          fetch_err_o;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .fetch_err_o (fetch_err_o)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int err_obs = 0;

  // Reference model: buffer contents plus one outstanding memory transaction.
  bit          m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  bit          m_pend;
  logic [31:0] m_req_addr;
  int          m_wait;
  bit          m_err;
  bit          last_stall;
  int          g_delay;  // >=0: ack after that many WAIT cycles, -1: never, -2: random

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h3401_1100;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_addr = '0; m_data = '0;
    m_pend = 0; m_req_addr = '0; m_wait = 0; m_err = 0;
  endtask

  // One clock cycle: drive at negedge, check 1ns later, then advance the model.
  task automatic cyc(input bit ce, input logic [31:0] addr, input bit late_ack);
    bit          ack;
    bit          hit;
    bit          exp_stall;
    logic [31:0] exp_data;
    @(negedge clk);
    ack = late_ack;
    if (m_pend) begin
      if (g_delay == -2) ack = ack || ($urandom_range(0, 3) == 0);
      else if (g_delay >= 0 && m_wait == g_delay) ack = 1;
    end
    rom_ce_i    = ce;
    rom_addr_i  = addr;
    mem_ack_i   = ack;
    mem_rdata_i = (ack && m_pend) ? mem_word(m_req_addr) : 32'($urandom);
    #1;
    hit       = ce && m_valid && (addr == m_addr);
    exp_stall = ce && !hit;
    exp_data  = hit ? m_data : 32'h0;
    chk("stall_o",     32'(stall_o),     32'(exp_stall));
    chk("rom_data_o",  rom_data_o,       exp_data);
    chk("mem_req_o",   32'(mem_req_o),   32'(m_pend));
    chk("fetch_err_o", 32'(fetch_err_o), 32'(m_err));
    if (m_pend) chk("mem_addr_o", mem_addr_o, m_req_addr);
    if (fetch_err_o) err_obs++;
    last_stall = exp_stall;
    m_err = 0;
    if (m_pend) begin
      if (ack) begin
        m_valid = 1; m_addr = m_req_addr; m_data = mem_word(m_req_addr); m_pend = 0;
      end else if (m_wait == int'(TMO) - 1) begin
        m_valid = 1; m_addr = m_req_addr; m_data = 32'h0; m_pend = 0; m_err = 1;
      end else begin
        m_wait++;
      end
    end else if (exp_stall) begin
      m_pend = 1; m_req_addr = addr; m_wait = 0;
    end
  endtask

  // Hold PC at addr until it stops stalling (bounded), then check the stall length.
  task automatic fetch(input logic [31:0] addr, input int delay, input int exp_stalls);
    int n;
    n = 0;
    g_delay = delay;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, addr, 1'b0);
      if (last_stall) n++;
      else break;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stalls));
  endtask

  logic [31:0] addr_tab [6] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h8000_0000, 32'hFFFF_FFFC};

  initial begin
    rst = 1'b0; rom_ce_i = 1'b0; rom_addr_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    model_reset();
    g_delay = 0;
    #12;
    chk("rst_mem_req",   32'(mem_req_o),   32'h0);
    chk("rst_mem_addr",  mem_addr_o,       32'h0);
    chk("rst_fetch_err", 32'(fetch_err_o), 32'h0);
    chk("rst_stall",     32'(stall_o),     32'h0);
    chk("rst_rom_data",  rom_data_o,       32'h0);
    @(negedge clk);
    rst = 1'b1;

    // First fetch with same-cycle ack, then hold the PC.
    fetch(32'h0, 0, 2);
    chk("t1_data", rom_data_o, 32'h3401_1100);
    repeat (5) cyc(1'b1, 32'h0, 1'b0);

    // Sequential PCs with a 3-cycle ack delay.
    fetch(32'h4, 3, 5);
    chk("t3_data4", rom_data_o, mem_word(32'h4));
    fetch(32'h8, 3, 5);
    chk("t3_data8", rom_data_o, mem_word(32'h8));

    // PC moves while a request is in flight.
    g_delay = 2;
    cyc(1'b1, 32'h40, 1'b0);
    repeat (3) cyc(1'b1, 32'h44, 1'b0);
    fetch(32'h44, 0, 2);

    // Full-width compare: high address bit must not alias with 0.
    fetch(32'h8000_0000, 1, 3);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h0, 1'b0);
    chk("alias_stall", 32'(stall_o), 32'h1);
    fetch(32'h0, 0, 1);

    // Timeout, NOP fill, single error pulse, late ack ignored.
    err_obs = 0;
    fetch(32'h10, -1, 5);
    chk("t4_nop", rom_data_o, 32'h0);
    cyc(1'b1, 32'h10, 1'b1);
    repeat (3) cyc(1'b1, 32'h10, 1'b0);
    chk("t4_err_pulses", 32'(err_obs), 32'h1);

    // Async reset in the middle of a WAIT.
    g_delay = -1;
    cyc(1'b1, 32'h80, 1'b0);
    cyc(1'b1, 32'h80, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req_o), 32'h0);
    rom_ce_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch(32'h0, 0, 2);
    fetch(32'h80, 1, 3);

    // Random traffic with random ack timing and stray acks in IDLE.
    g_delay = -2;
    repeat (300) begin
      cyc($urandom_range(0, 7) != 0, addr_tab[$urandom_range(0, 5)], $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
